// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and match helper for the MIPS pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // EX operand mux selects
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Hazard FSM state encodings
  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_LSTALL = 1'b1;

  // $zero is hard-wired; it never carries a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a writing stage's destination feeds the given source register
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] dst,
                                   input logic [4:0] src);
    return we && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational forwarding selects for the EX ALU operands and the WB->ID bypass.
module pipe_hazard_ctrl_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] idex_rs,
  input  logic [4:0] idex_rt,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_wreg,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_wreg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       fwdid_a,
  output logic       fwdid_b
);

  // EX/MEM is checked first: it holds the youngest value of a register
  always_comb begin
    fwd_a = FWD_REG;
    if (reg_hit(exmem_regwrite, exmem_wreg, idex_rs)) begin
      fwd_a = FWD_EXMEM;
    end else if (reg_hit(memwb_regwrite, memwb_wreg, idex_rs)) begin
      fwd_a = FWD_MEMWB;
    end

    fwd_b = FWD_REG;
    if (reg_hit(exmem_regwrite, exmem_wreg, idex_rt)) begin
      fwd_b = FWD_EXMEM;
    end else if (reg_hit(memwb_regwrite, memwb_wreg, idex_rt)) begin
      fwd_b = FWD_MEMWB;
    end
  end

  // Register file reads in ID see the value being written back this cycle
  always_comb begin
    fwdid_a = reg_hit(memwb_regwrite, memwb_wreg, id_rs);
    fwdid_b = reg_hit(memwb_regwrite, memwb_wreg, id_rt);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use interlock, taken-branch
// flush, EX forwarding selects, WB->ID bypass and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_USES_RS,
  input  logic             ID_USES_RT,
  input  logic [4:0]       IDEX_RS,
  input  logic [4:0]       IDEX_RT,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_WREG,
  input  logic             EXMEM_RegWrite,
  input  logic [4:0]       EXMEM_WREG,
  input  logic             MEMWB_RegWrite,
  input  logic [4:0]       MEMWB_WREG,
  input  logic             PC_SRC,
  output logic             PC_WRITE,
  output logic             IFID_WRITE,
  output logic             IFID_FLUSH,
  output logic             IDEX_BUBBLE,
  output logic             EXMEM_FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             FWDID_A,
  output logic             FWDID_B,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  import pipe_hazard_ctrl_pkg::*;

  // The first stall cycle is spent in RUN; LSTALL covers the remaining ones
  localparam int unsigned CNT_INIT_INT = (LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0;
  localparam logic [3:0]  CNT_INIT     = CNT_INIT_INT[3:0];

  logic             state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall;

  pipe_hazard_ctrl_fwd_unit u_fwd_unit (
    .id_rs          (ID_RS),
    .id_rt          (ID_RT),
    .idex_rs        (IDEX_RS),
    .idex_rt        (IDEX_RT),
    .exmem_regwrite (EXMEM_RegWrite),
    .exmem_wreg     (EXMEM_WREG),
    .memwb_regwrite (MEMWB_RegWrite),
    .memwb_wreg     (MEMWB_WREG),
    .fwd_a          (FWD_A),
    .fwd_b          (FWD_B),
    .fwdid_a        (FWDID_A),
    .fwdid_b        (FWDID_B)
  );

  // Load-use detection and stall/flush outputs; a taken branch overrides any stall
  always_comb begin
    lu = IDEX_MemRead && (IDEX_WREG != REG_ZERO) &&
         ((ID_USES_RS && (IDEX_WREG == ID_RS)) || (ID_USES_RT && (IDEX_WREG == ID_RT)));
    stall = !PC_SRC && (((state_q == ST_RUN) && lu) || (state_q == ST_LSTALL));

    PC_WRITE    = !stall;
    IFID_WRITE  = !stall;
    IFID_FLUSH  = PC_SRC;
    IDEX_BUBBLE = stall || PC_SRC;
    EXMEM_FLUSH = PC_SRC;
  end

  // FSM next state: extend a load-use stall, abort it on a taken branch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (PC_SRC) begin
      state_d = ST_RUN;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu && (LOAD_STALL_CYCLES > 1)) begin
            state_d = ST_LSTALL;
            cnt_d   = CNT_INIT;
          end
        end
        ST_LSTALL: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_WRITE && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (PC_SRC && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three instances share the stimulus
// (dut0: 1 stall cycle, dut1: 3 stall cycles, dut2: 1 stall cycle with 4-bit counters).
module tb_pipe_hazard_ctrl;

  localparam int D1 = 0;
  localparam int D3 = 1;
  localparam int D4 = 2;

  localparam int S_PCW = 0;
  localparam int S_IFW = 1;
  localparam int S_IFF = 2;
  localparam int S_BUB = 3;
  localparam int S_EXF = 4;
  localparam int S_FA  = 5;
  localparam int S_FB  = 6;
  localparam int S_FIA = 7;
  localparam int S_FIB = 8;
  localparam int S_SC  = 9;
  localparam int S_FC  = 10;

  typedef struct packed {
    logic [7:0]  test;
    logic [1:0]  dut;
    logic [3:0]  sig;
    logic [31:0] exp;
  } chk_t;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_rs, idex_rt, idex_wreg, exmem_wreg, memwb_wreg;
  logic       id_uses_rs, id_uses_rt, idex_memread, exmem_regwrite, memwb_regwrite, pc_src;

  logic       pc_write [3];
  logic       ifid_write [3];
  logic       ifid_flush [3];
  logic       idex_bubble [3];
  logic       exmem_flush [3];
  logic [1:0] fwd_a [3];
  logic [1:0] fwd_b [3];
  logic       fwdid_a [3];
  logic       fwdid_b [3];
  logic [15:0] stall_cnt_1, flush_cnt_1, stall_cnt_3, flush_cnt_3;
  logic [3:0]  stall_cnt_4, flush_cnt_4;

  chk_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cur_test = 0;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut1 (
    .CLK(clk), .RST(rst), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_uses_rs),
    .ID_USES_RT(id_uses_rt), .IDEX_RS(idex_rs), .IDEX_RT(idex_rt), .IDEX_MemRead(idex_memread),
    .IDEX_WREG(idex_wreg), .EXMEM_RegWrite(exmem_regwrite), .EXMEM_WREG(exmem_wreg),
    .MEMWB_RegWrite(memwb_regwrite), .MEMWB_WREG(memwb_wreg), .PC_SRC(pc_src),
    .PC_WRITE(pc_write[0]), .IFID_WRITE(ifid_write[0]), .IFID_FLUSH(ifid_flush[0]),
    .IDEX_BUBBLE(idex_bubble[0]), .EXMEM_FLUSH(exmem_flush[0]), .FWD_A(fwd_a[0]),
    .FWD_B(fwd_b[0]), .FWDID_A(fwdid_a[0]), .FWDID_B(fwdid_b[0]), .STALL_CNT(stall_cnt_1),
    .FLUSH_CNT(flush_cnt_1)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_dut3 (
    .CLK(clk), .RST(rst), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_uses_rs),
    .ID_USES_RT(id_uses_rt), .IDEX_RS(idex_rs), .IDEX_RT(idex_rt), .IDEX_MemRead(idex_memread),
    .IDEX_WREG(idex_wreg), .EXMEM_RegWrite(exmem_regwrite), .EXMEM_WREG(exmem_wreg),
    .MEMWB_RegWrite(memwb_regwrite), .MEMWB_WREG(memwb_wreg), .PC_SRC(pc_src),
    .PC_WRITE(pc_write[1]), .IFID_WRITE(ifid_write[1]), .IFID_FLUSH(ifid_flush[1]),
    .IDEX_BUBBLE(idex_bubble[1]), .EXMEM_FLUSH(exmem_flush[1]), .FWD_A(fwd_a[1]),
    .FWD_B(fwd_b[1]), .FWDID_A(fwdid_a[1]), .FWDID_B(fwdid_b[1]), .STALL_CNT(stall_cnt_3),
    .FLUSH_CNT(flush_cnt_3)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_dut4 (
    .CLK(clk), .RST(rst), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_uses_rs),
    .ID_USES_RT(id_uses_rt), .IDEX_RS(idex_rs), .IDEX_RT(idex_rt), .IDEX_MemRead(idex_memread),
    .IDEX_WREG(idex_wreg), .EXMEM_RegWrite(exmem_regwrite), .EXMEM_WREG(exmem_wreg),
    .MEMWB_RegWrite(memwb_regwrite), .MEMWB_WREG(memwb_wreg), .PC_SRC(pc_src),
    .PC_WRITE(pc_write[2]), .IFID_WRITE(ifid_write[2]), .IFID_FLUSH(ifid_flush[2]),
    .IDEX_BUBBLE(idex_bubble[2]), .EXMEM_FLUSH(exmem_flush[2]), .FWD_A(fwd_a[2]),
    .FWD_B(fwd_b[2]), .FWDID_A(fwdid_a[2]), .FWDID_B(fwdid_b[2]), .STALL_CNT(stall_cnt_4),
    .FLUSH_CNT(flush_cnt_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sig_name(input int s);
    case (s)
      S_PCW:   return "PC_WRITE";
      S_IFW:   return "IFID_WRITE";
      S_IFF:   return "IFID_FLUSH";
      S_BUB:   return "IDEX_BUBBLE";
      S_EXF:   return "EXMEM_FLUSH";
      S_FA:    return "FWD_A";
      S_FB:    return "FWD_B";
      S_FIA:   return "FWDID_A";
      S_FIB:   return "FWDID_B";
      S_SC:    return "STALL_CNT";
      default: return "FLUSH_CNT";
    endcase
  endfunction

  function automatic int get_out(input int d, input int s);
    case (s)
      S_PCW: return int'(pc_write[d]);
      S_IFW: return int'(ifid_write[d]);
      S_IFF: return int'(ifid_flush[d]);
      S_BUB: return int'(idex_bubble[d]);
      S_EXF: return int'(exmem_flush[d]);
      S_FA:  return int'(fwd_a[d]);
      S_FB:  return int'(fwd_b[d]);
      S_FIA: return int'(fwdid_a[d]);
      S_FIB: return int'(fwdid_b[d]);
      S_SC: begin
        if (d == D4) return int'(stall_cnt_4);
        else if (d == D3) return int'(stall_cnt_3);
        else return int'(stall_cnt_1);
      end
      default: begin
        if (d == D4) return int'(flush_cnt_4);
        else if (d == D3) return int'(flush_cnt_3);
        else return int'(flush_cnt_1);
      end
    endcase
  endfunction

  task automatic expect_out(input int d, input int s, input int e);
    chk_t c;
    c.test = 8'(cur_test);
    c.dut  = 2'(d);
    c.sig  = 4'(s);
    c.exp  = 32'(e);
    sb_q.push_back(c);
  endtask

  // Monitor: outputs are compared on the falling edge, half a cycle after inputs move
  initial begin
    chk_t c;
    int   act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        c   = sb_q.pop_front();
        act = get_out(int'(c.dut), int'(c.sig));
        total++;
        if (act != int'(c.exp)) begin
          bad++;
          $display("FAIL t%0d dut%0d %s: got=%0d exp=%0d", c.test, c.dut,
                   sig_name(int'(c.sig)), act, c.exp);
        end
      end
    end
  end

  task automatic drv_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    idex_rs = 5'd0; idex_rt = 5'd0; idex_memread = 1'b0; idex_wreg = 5'd0;
    exmem_regwrite = 1'b0; exmem_wreg = 5'd0;
    memwb_regwrite = 1'b0; memwb_wreg = 5'd0;
    pc_src = 1'b0;
  endtask

  // lw $2,0($1) in EX, add $3,$2,$4 in ID
  task automatic drv_lu();
    drv_idle();
    idex_memread = 1'b1; idex_wreg = 5'd2; idex_rs = 5'd1; idex_rt = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    drv_idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drv_idle();
    // Reset state on all instances
    for (int d = 0; d < 3; d++) begin
      expect_out(d, S_PCW, 1); expect_out(d, S_IFW, 1); expect_out(d, S_IFF, 0);
      expect_out(d, S_BUB, 0); expect_out(d, S_EXF, 0); expect_out(d, S_FA, 0);
      expect_out(d, S_FB, 0);  expect_out(d, S_SC, 0);  expect_out(d, S_FC, 0);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;

    // 1: load-use, one stall cycle, then MEM/WB forwarding
    cur_test = 1;
    step(); drv_lu();
    expect_out(D1, S_PCW, 0); expect_out(D1, S_IFW, 0); expect_out(D1, S_BUB, 1);
    expect_out(D1, S_IFF, 0); expect_out(D1, S_FA, 0);  expect_out(D1, S_FB, 0);
    expect_out(D1, S_SC, 0);  expect_out(D3, S_PCW, 0); expect_out(D4, S_PCW, 0);
    step(); drv_idle();
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    exmem_regwrite = 1'b1; exmem_wreg = 5'd2;
    expect_out(D1, S_PCW, 1); expect_out(D1, S_BUB, 0); expect_out(D1, S_SC, 1);
    expect_out(D3, S_PCW, 0);
    step(); drv_idle();
    idex_rs = 5'd2; idex_rt = 5'd4; idex_wreg = 5'd3;
    memwb_regwrite = 1'b1; memwb_wreg = 5'd2;
    expect_out(D1, S_FA, 1);  expect_out(D1, S_FB, 0);  expect_out(D1, S_PCW, 1);
    expect_out(D1, S_SC, 1);  expect_out(D4, S_SC, 1);  expect_out(D3, S_PCW, 0);
    expect_out(D3, S_SC, 2);
    step(); drv_idle();
    expect_out(D3, S_PCW, 1); expect_out(D3, S_SC, 3);

    // 2: EX/MEM and MEM/WB forwarding, priority
    cur_test = 2;
    do_reset();
    step(); drv_idle();
    exmem_regwrite = 1'b1; exmem_wreg = 5'd2;
    idex_rs = 5'd2; idex_rt = 5'd2; idex_wreg = 5'd5;
    id_rs = 5'd2; id_uses_rs = 1'b1;
    expect_out(D1, S_FA, 2); expect_out(D1, S_FB, 2); expect_out(D1, S_PCW, 1);
    expect_out(D1, S_SC, 0);
    step(); drv_idle();
    memwb_regwrite = 1'b1; memwb_wreg = 5'd2;
    exmem_regwrite = 1'b1; exmem_wreg = 5'd5;
    idex_rs = 5'd2; idex_rt = 5'd0; idex_wreg = 5'd6;
    expect_out(D1, S_FA, 1); expect_out(D1, S_FB, 0);
    step(); drv_idle();
    exmem_regwrite = 1'b1; exmem_wreg = 5'd2; memwb_regwrite = 1'b1; memwb_wreg = 5'd2;
    idex_rs = 5'd2; idex_rt = 5'd2;
    expect_out(D1, S_FA, 2); expect_out(D1, S_FB, 2);
    step(); drv_idle();
    exmem_regwrite = 1'b0; exmem_wreg = 5'd2; memwb_regwrite = 1'b1; memwb_wreg = 5'd2;
    idex_rs = 5'd2; idex_rt = 5'd3;
    expect_out(D1, S_FA, 1); expect_out(D1, S_FB, 0);
    step(); drv_idle();
    exmem_regwrite = 1'b1; exmem_wreg = 5'd3; memwb_regwrite = 1'b1; memwb_wreg = 5'd2;
    idex_rs = 5'd3; idex_rt = 5'd2;
    expect_out(D1, S_FA, 2); expect_out(D1, S_FB, 1);

    // 3: taken branch flush overrides a simultaneous load-use
    cur_test = 3;
    do_reset();
    step(); drv_lu(); pc_src = 1'b1;
    expect_out(D1, S_IFF, 1); expect_out(D1, S_BUB, 1); expect_out(D1, S_EXF, 1);
    expect_out(D1, S_PCW, 1); expect_out(D1, S_IFW, 1); expect_out(D1, S_FC, 0);
    expect_out(D3, S_PCW, 1);
    step(); drv_idle();
    expect_out(D1, S_IFF, 0); expect_out(D1, S_BUB, 0); expect_out(D1, S_EXF, 0);
    expect_out(D1, S_FC, 1);  expect_out(D1, S_SC, 0);  expect_out(D3, S_PCW, 1);
    expect_out(D3, S_SC, 0);  expect_out(D4, S_FC, 1);

    // 4: three-cycle stall, then abort by a branch in the second stall cycle
    cur_test = 4;
    do_reset();
    step(); drv_lu();
    expect_out(D3, S_PCW, 0); expect_out(D3, S_IFW, 0); expect_out(D3, S_BUB, 1);
    step(); drv_idle();
    expect_out(D3, S_PCW, 0); expect_out(D3, S_IFW, 0); expect_out(D3, S_BUB, 1);
    expect_out(D3, S_IFF, 0); expect_out(D3, S_SC, 1);
    step(); drv_idle();
    expect_out(D3, S_PCW, 0); expect_out(D3, S_SC, 2);
    step(); drv_idle();
    expect_out(D3, S_PCW, 1); expect_out(D3, S_IFW, 1); expect_out(D3, S_BUB, 0);
    expect_out(D3, S_SC, 3);
    do_reset();
    step(); drv_lu();
    expect_out(D3, S_PCW, 0);
    step(); drv_idle(); pc_src = 1'b1;
    expect_out(D3, S_PCW, 1); expect_out(D3, S_IFW, 1); expect_out(D3, S_IFF, 1);
    expect_out(D3, S_BUB, 1); expect_out(D3, S_EXF, 1); expect_out(D3, S_SC, 1);
    expect_out(D3, S_FC, 0);
    step(); drv_idle();
    expect_out(D3, S_PCW, 1); expect_out(D3, S_BUB, 0); expect_out(D3, S_SC, 1);
    expect_out(D3, S_FC, 1);

    // 5: $0 never matches; WB->ID bypass; unused source fields ignored
    cur_test = 5;
    do_reset();
    step(); drv_idle();
    idex_memread = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
    expect_out(D1, S_PCW, 1); expect_out(D1, S_BUB, 0); expect_out(D1, S_FA, 0);
    expect_out(D1, S_FB, 0);  expect_out(D1, S_FIA, 0); expect_out(D1, S_FIB, 0);
    step(); drv_idle();
    memwb_regwrite = 1'b1; memwb_wreg = 5'd7; id_rs = 5'd7; id_rt = 5'd3;
    expect_out(D1, S_FIA, 1); expect_out(D1, S_FIB, 0);
    step(); drv_idle();
    memwb_regwrite = 1'b1; memwb_wreg = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
    expect_out(D1, S_FIA, 0); expect_out(D1, S_FIB, 1);
    step(); drv_idle();
    memwb_regwrite = 1'b0; memwb_wreg = 5'd7; id_rs = 5'd7; id_rt = 5'd7;
    expect_out(D1, S_FIA, 0); expect_out(D1, S_FIB, 0);
    step(); drv_idle();
    idex_memread = 1'b1; idex_wreg = 5'd4; id_rs = 5'd4; id_rt = 5'd4;
    expect_out(D1, S_PCW, 1);
    step(); drv_idle();
    idex_memread = 1'b1; idex_wreg = 5'd4; id_rs = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
    expect_out(D1, S_PCW, 0);

    // 6: asynchronous reset in LSTALL, then counter saturation
    cur_test = 6;
    do_reset();
    step(); drv_lu();
    expect_out(D3, S_PCW, 0);
    step(); drv_idle();
    #2;
    rst = 1'b1;
    expect_out(D3, S_PCW, 1); expect_out(D3, S_SC, 0); expect_out(D3, S_FC, 0);
    expect_out(D1, S_SC, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(); drv_lu();
    end
    step(); drv_lu();
    expect_out(D4, S_SC, 15); expect_out(D1, S_SC, 20); expect_out(D4, S_PCW, 0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(); drv_idle(); pc_src = 1'b1;
    end
    step(); drv_idle();
    expect_out(D4, S_FC, 15); expect_out(D1, S_FC, 17);

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
